id_ex_stage_reg: RTL and testbench

Parametrised ID/EX pipeline register with valid/ready flow control, flush, and a stall-cycle counter. It replaces the free-running ID/EX register between the decode/control unit and the execute stage. It carries decoded instruction fields and extend select, and inserts a canonical NOP bubble on reset and flush. An optional skid entry registers the upstream ready.

---
 rtl/id_ex_stage_reg_pkg.sv | 22 ++
 rtl/id_ex_payload_slot.sv | 40 ++++
 rtl/id_ex_stage_reg.sv | 156 +++++++++++++++
 tb/tb_id_ex_stage_reg.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_reg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | id_ex_stage_reg_pkg                                                  |
// | Shared constants and bubble helper for the ID/EX pipeline register.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package id_ex_stage_reg_pkg;

  // addi x0,x0,0 opcode used for every bubble
  localparam logic [6:0] NOP_OPCODE       = 7'b0010011;
  localparam int unsigned MAX_PAYLOAD_BITS = 1024;

  // Opcode sits in the top seven bits of the packed payload; all else is zero.
  function automatic logic [MAX_PAYLOAD_BITS-1:0] bubble_bits(input int unsigned width);
    logic [MAX_PAYLOAD_BITS-1:0] v;
    v = '0;
    v[width-1 -: 7] = NOP_OPCODE;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/id_ex_payload_slot.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | id_ex_payload_slot                                                   |
// | One valid + payload register with load, clear-to-bubble and hold.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module id_ex_payload_slot #(
  parameter int unsigned      WIDTH  = 8,
  parameter logic [WIDTH-1:0] BUBBLE = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic             valid,
  output logic [WIDTH-1:0] q
);

  logic             r_valid;
  logic [WIDTH-1:0] r_payload;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_valid   <= 1'b0;
      r_payload <= BUBBLE;
    end else if (clear) begin
      r_valid   <= 1'b0;
      r_payload <= BUBBLE;
    end else if (load) begin
      r_valid   <= 1'b1;
      r_payload <= d;
    end
  end

  assign valid = r_valid;
  assign q     = r_payload;

endmodule
`default_nettype wire

// File: rtl/id_ex_stage_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | id_ex_stage_reg                                                      |
// | ID/EX pipeline register: valid/ready, flush-to-NOP, stall counter.   |
// | Optional skid entry (registered id_ready) under `ID_EX_SKID_EN.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module id_ex_stage_reg
  import id_ex_stage_reg_pkg::*;
#(
  parameter int CORE           = 0,
  parameter int ADDRESS_BITS   = 20,
  parameter int DATA_WIDTH     = 32,
  parameter int STALL_CNT_BITS = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      id_valid,
  output logic                      id_ready,
  input  logic [6:0]                id_opcode,
  input  logic [2:0]                id_funct3,
  input  logic [6:0]                id_funct7,
  input  logic [DATA_WIDTH-1:0]     id_rs1_data,
  input  logic [DATA_WIDTH-1:0]     id_rs2_data,
  input  logic [4:0]                id_rd,
  input  logic [DATA_WIDTH-1:0]     id_extend_imm,
  input  logic [ADDRESS_BITS-1:0]   id_branch_target,
  input  logic [ADDRESS_BITS-1:0]   id_JAL_target,
  input  logic [1:0]                cu_extend_sel,
  output logic                      ex_valid,
  input  logic                      ex_ready,
  output logic [6:0]                ex_opcode,
  output logic [2:0]                ex_funct3,
  output logic [6:0]                ex_funct7,
  output logic [DATA_WIDTH-1:0]     ex_rs1_data,
  output logic [DATA_WIDTH-1:0]     ex_rs2_data,
  output logic [4:0]                ex_rd,
  output logic [DATA_WIDTH-1:0]     ex_extend_imm,
  output logic [ADDRESS_BITS-1:0]   ex_branch_target,
  output logic [ADDRESS_BITS-1:0]   ex_JAL_target,
  output logic [1:0]                ex_extend_sel,
  output logic [STALL_CNT_BITS-1:0] stall_count
);

  typedef struct packed {
    logic [6:0]              opcode;
    logic [2:0]              funct3;
    logic [6:0]              funct7;
    logic [DATA_WIDTH-1:0]   rs1_data;
    logic [DATA_WIDTH-1:0]   rs2_data;
    logic [4:0]              rd;
    logic [DATA_WIDTH-1:0]   extend_imm;
    logic [ADDRESS_BITS-1:0] branch_target;
    logic [ADDRESS_BITS-1:0] jal_target;
    logic [1:0]              extend_sel;
  } id_ex_payload_t;

  localparam int unsigned c_payload_bits = $bits(id_ex_payload_t);
  localparam logic [c_payload_bits-1:0] c_bubble =
    c_payload_bits'(bubble_bits(c_payload_bits));

  if (CORE < 0 || c_payload_bits > MAX_PAYLOAD_BITS) begin : g_param_check
    $error("id_ex_stage_reg: CORE must be non-negative and payload must fit MAX_PAYLOAD_BITS");
  end

  id_ex_payload_t w_id_payload;
  id_ex_payload_t w_main_d;
  id_ex_payload_t w_main_q;
  logic           w_main_valid;
  logic           w_main_load;
  logic           w_main_clear;
  logic           w_main_free;
  logic           w_accept;
  logic           w_consume;

  assign w_id_payload = {id_opcode, id_funct3, id_funct7, id_rs1_data, id_rs2_data,
                         id_rd, id_extend_imm, id_branch_target, id_JAL_target,
                         cu_extend_sel};

  assign w_consume   = w_main_valid & ex_ready;
  assign w_main_free = ~w_main_valid | ex_ready;

`ifdef ID_EX_SKID_EN
  id_ex_payload_t w_skid_q;
  logic           w_skid_valid;
  logic           w_skid_load;
  logic           w_skid_clear;

  // Skid drains into main before any new input is taken.
  assign id_ready     = ~w_skid_valid;
  assign w_accept     = id_valid & id_ready;
  assign w_main_d     = w_skid_valid ? w_skid_q : w_id_payload;
  assign w_main_load  = ~flush & w_main_free & (w_skid_valid | w_accept);
  assign w_main_clear = flush | (w_consume & ~w_skid_valid & ~w_accept);
  assign w_skid_load  = ~flush & w_accept & ~w_main_free;
  assign w_skid_clear = flush | (w_skid_valid & w_main_free);

  id_ex_payload_slot #(
    .WIDTH  (c_payload_bits),
    .BUBBLE (c_bubble)
  ) u_skid (
    .clock (clock),
    .reset (reset),
    .load  (w_skid_load),
    .clear (w_skid_clear),
    .d     (w_id_payload),
    .valid (w_skid_valid),
    .q     (w_skid_q)
  );
`else
  assign id_ready     = w_main_free;
  assign w_accept     = id_valid & id_ready;
  assign w_main_d     = w_id_payload;
  assign w_main_load  = ~flush & w_accept;
  assign w_main_clear = flush | (w_consume & ~w_accept);
`endif

  id_ex_payload_slot #(
    .WIDTH  (c_payload_bits),
    .BUBBLE (c_bubble)
  ) u_main (
    .clock (clock),
    .reset (reset),
    .load  (w_main_load),
    .clear (w_main_clear),
    .d     (w_main_d),
    .valid (w_main_valid),
    .q     (w_main_q)
  );

  logic [STALL_CNT_BITS-1:0] r_stall_count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_stall_count <= '0;
    end else if (w_main_valid & ~ex_ready & ~flush & ~(&r_stall_count)) begin
      r_stall_count <= r_stall_count + 1'b1;
    end
  end

  assign stall_count      = r_stall_count;
  assign ex_valid         = w_main_valid;
  assign ex_opcode        = w_main_q.opcode;
  assign ex_funct3        = w_main_q.funct3;
  assign ex_funct7        = w_main_q.funct7;
  assign ex_rs1_data      = w_main_q.rs1_data;
  assign ex_rs2_data      = w_main_q.rs2_data;
  assign ex_rd            = w_main_q.rd;
  assign ex_extend_imm    = w_main_q.extend_imm;
  assign ex_branch_target = w_main_q.branch_target;
  assign ex_JAL_target    = w_main_q.jal_target;
  assign ex_extend_sel    = w_main_q.extend_sel;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_id_ex_stage_reg                                                   |
// | Scoreboard bench for id_ex_stage_reg (either ID_EX_SKID_EN build).   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_id_ex_stage_reg;

  localparam int AB  = 20;
  localparam int DW  = 32;
  localparam int SCB = 4;
`ifdef ID_EX_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  typedef struct packed {
    logic [6:0]    opcode;
    logic [2:0]    funct3;
    logic [6:0]    funct7;
    logic [DW-1:0] rs1_data;
    logic [DW-1:0] rs2_data;
    logic [4:0]    rd;
    logic [DW-1:0] extend_imm;
    logic [AB-1:0] branch_target;
    logic [AB-1:0] jal_target;
    logic [1:0]    extend_sel;
  } pl_t;

  logic clock    = 1'b0;
  logic reset    = 1'b0;
  logic flush    = 1'b0;
  logic id_valid = 1'b0;
  logic ex_ready = 1'b0;
  pl_t  cur      = '0;

  logic           id_ready, ex_valid;
  logic [6:0]     ex_opcode, ex_funct7;
  logic [2:0]     ex_funct3;
  logic [DW-1:0]  ex_rs1_data, ex_rs2_data, ex_extend_imm;
  logic [4:0]     ex_rd;
  logic [AB-1:0]  ex_branch_target, ex_JAL_target;
  logic [1:0]     ex_extend_sel;
  logic [SCB-1:0] stall_count;
  pl_t            ex_pl;

  pl_t         sb[$];
  logic [4:0]  consumed_rd[$];
  int          checks = 0;
  int          errors = 0;

  always #5 clock = ~clock;

  assign ex_pl = {ex_opcode, ex_funct3, ex_funct7, ex_rs1_data, ex_rs2_data, ex_rd,
                  ex_extend_imm, ex_branch_target, ex_JAL_target, ex_extend_sel};

  id_ex_stage_reg #(
    .CORE(0), .ADDRESS_BITS(AB), .DATA_WIDTH(DW), .STALL_CNT_BITS(SCB)
  ) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_opcode(cur.opcode), .id_funct3(cur.funct3), .id_funct7(cur.funct7),
    .id_rs1_data(cur.rs1_data), .id_rs2_data(cur.rs2_data), .id_rd(cur.rd),
    .id_extend_imm(cur.extend_imm), .id_branch_target(cur.branch_target),
    .id_JAL_target(cur.jal_target), .cu_extend_sel(cur.extend_sel),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_opcode(ex_opcode), .ex_funct3(ex_funct3), .ex_funct7(ex_funct7),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_rd(ex_rd),
    .ex_extend_imm(ex_extend_imm), .ex_branch_target(ex_branch_target),
    .ex_JAL_target(ex_JAL_target), .ex_extend_sel(ex_extend_sel),
    .stall_count(stall_count)
  );

  task automatic set_payload(input logic [4:0] rd);
    cur.opcode        = 7'($urandom);
    cur.funct3        = 3'($urandom);
    cur.funct7        = 7'($urandom);
    cur.rs1_data      = $urandom;
    cur.rs2_data      = $urandom;
    cur.rd            = rd;
    cur.extend_imm    = $urandom;
    cur.branch_target = AB'($urandom);
    cur.jal_target    = AB'($urandom);
    cur.extend_sel    = 2'($urandom);
  endtask

  // Scoreboard step: score the handshakes of this cycle, then advance one clock.
  task automatic tick();
    pl_t exp;
    #1;
    if (flush) begin
      sb.delete();
    end else begin
      if (ex_valid && ex_ready) begin
        consumed_rd.push_back(ex_rd);
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_underflow: consumed rd=%0d, required nothing pending", ex_rd);
        end else begin
          exp = sb.pop_front();
          if (ex_pl !== exp) begin
            errors++;
            $display("FAIL sb_payload: got %h required %h", ex_pl, exp);
          end
        end
      end
      if (id_valid && id_ready) sb.push_back(cur);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0; flush = 1'b0; id_valid = 1'b0; ex_ready = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    sb.delete();
    consumed_rd.delete();
  endtask

  task automatic test_reset();
    reset = 1'b0; id_valid = 1'b1; ex_ready = 1'b0;
    set_payload(5'd9);
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (ex_valid !== 1'b0) begin errors++; $display("FAIL rst_ex_valid: got %b required 0", ex_valid); end
    checks++;
    if (ex_opcode !== 7'h13 || ex_rd !== 5'd0 || ex_extend_imm !== '0) begin
      errors++; $display("FAIL rst_bubble: got op=%h rd=%0d imm=%h required op=13 rd=0 imm=0", ex_opcode, ex_rd, ex_extend_imm);
    end
    checks++;
    if (stall_count !== 4'd0) begin errors++; $display("FAIL rst_stall: got %0d required 0", stall_count); end
    checks++;
    if (id_ready !== 1'b1) begin errors++; $display("FAIL rst_id_ready: got %b required 1", id_ready); end
    id_valid = 1'b0;
    reset = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_streaming();
    apply_reset();
    ex_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      set_payload(5'(i));
      id_valid = 1'b1;
      tick();
      checks++;
      if (ex_valid !== 1'b1 || ex_rd !== 5'(i)) begin
        errors++; $display("FAIL stream_latency: got valid=%b rd=%0d required valid=1 rd=%0d", ex_valid, ex_rd, i);
      end
    end
    id_valid = 1'b0;
    tick();
    checks++;
    if (ex_valid !== 1'b0 || ex_opcode !== 7'h13) begin
      errors++; $display("FAIL stream_drain: got valid=%b op=%h required valid=0 op=13", ex_valid, ex_opcode);
    end
    checks++;
    if (stall_count !== 4'd0) begin errors++; $display("FAIL stream_stall: got %0d required 0", stall_count); end
  endtask

  task automatic test_back_pressure();
    logic exp_ready;
    apply_reset();
    set_payload(5'd7);
    id_valid = 1'b1;
    tick();
    set_payload(5'd8);
    for (int k = 0; k < 5; k++) begin
      exp_ready = SKID && (k == 0);
      #1;
      checks++;
      if (id_ready !== exp_ready) begin
        errors++; $display("FAIL bp_id_ready[%0d]: got %b required %b", k, id_ready, exp_ready);
      end
      tick();
      checks++;
      if (ex_valid !== 1'b1 || ex_rd !== 5'd7) begin
        errors++; $display("FAIL bp_hold[%0d]: got valid=%b rd=%0d required valid=1 rd=7", k, ex_valid, ex_rd);
      end
    end
    checks++;
    if (stall_count !== 4'd5) begin errors++; $display("FAIL bp_stall: got %0d required 5", stall_count); end
    // Reset dropped mid-stall must act without waiting for a clock edge.
    reset = 1'b0;
    #1;
    checks++;
    if (ex_valid !== 1'b0 || stall_count !== 4'd0 || ex_opcode !== 7'h13 || id_ready !== 1'b1) begin
      errors++; $display("FAIL async_reset: got valid=%b stall=%0d op=%h ready=%b required 0/0/13/1", ex_valid, stall_count, ex_opcode, id_ready);
    end
    id_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    sb.delete();
  endtask

  task automatic test_flush();
    apply_reset();
    set_payload(5'd3);
    id_valid = 1'b1;
    tick();
    set_payload(5'd4);
    tick();
    set_payload(5'd5);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    id_valid = 1'b0;
    checks++;
    if (ex_valid !== 1'b0 || ex_opcode !== 7'h13 || ex_rd !== 5'd0) begin
      errors++; $display("FAIL flush_bubble: got valid=%b op=%h rd=%0d required 0/13/0", ex_valid, ex_opcode, ex_rd);
    end
    checks++;
    if (stall_count !== 4'd1) begin errors++; $display("FAIL flush_stall: got %0d required 1", stall_count); end
    tick();
    checks++;
    if (ex_valid !== 1'b0 || id_ready !== 1'b1) begin
      errors++; $display("FAIL flush_skid_empty: got valid=%b ready=%b required 0/1", ex_valid, id_ready);
    end
    checks++;
    if (stall_count !== 4'd1) begin errors++; $display("FAIL flush_stall_hold: got %0d required 1", stall_count); end
  endtask

  task automatic test_saturation();
    logic [SCB-1:0] exp;
    int n;
    apply_reset();
    set_payload(5'd6);
    id_valid = 1'b1;
    tick();
    id_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      exp = (k > 15) ? 4'd15 : SCB'(k);
      checks++;
      if (stall_count !== exp) begin
        errors++; $display("FAIL sat_count[%0d]: got %0d required %0d", k, stall_count, exp);
      end
    end
    ex_ready = 1'b1;
    n = 0;
    while (sb.size() > 0 && n < 10) begin tick(); n++; end
    checks++;
    if (sb.size() != 0 || ex_valid !== 1'b0) begin
      errors++; $display("FAIL sat_drain: got pending=%0d valid=%b required 0/0", sb.size(), ex_valid);
    end
    checks++;
    if (stall_count !== 4'd15) begin errors++; $display("FAIL sat_hold: got %0d required 15", stall_count); end
  endtask

`ifdef ID_EX_SKID_EN
  task automatic test_skid_order();
    logic took;
    int   n;
    apply_reset();
    set_payload(5'd1); id_valid = 1'b1; tick();
    set_payload(5'd2); tick();
    set_payload(5'd3);
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if (id_ready !== 1'b0) begin errors++; $display("FAIL skid_full_ready[%0d]: got %b required 0", k, id_ready); end
      tick();
    end
    ex_ready = 1'b1;
    n = 0;
    while ((sb.size() > 0 || id_valid) && n < 10) begin
      #1;
      took = id_valid && id_ready;
      tick();
      if (took) id_valid = 1'b0;
      n++;
    end
    checks++;
    if (n >= 10) begin errors++; $display("FAIL skid_timeout: got %0d cycles required under 10", n); end
    checks++;
    if (consumed_rd.size() != 3 || consumed_rd[0] !== 5'd1 || consumed_rd[1] !== 5'd2 || consumed_rd[2] !== 5'd3) begin
      errors++; $display("FAIL skid_order: got %0d items required rd 1,2,3", consumed_rd.size());
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_streaming();
    test_back_pressure();
    test_flush();
    test_saturation();
`ifdef ID_EX_SKID_EN
    test_skid_order();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
